// File: rtl/rv_csr_mt_if.sv
// rv_csr_mt_if: request/response bus of the multi-hart CSR file.
//   master : execute-stage side, drives req_*, receives resp_*
//   slave  : CSR file side, receives req_*, drives resp_*
// Signals:
//   req_valid    CSR access request
//   req_hart     target hart (HART_W bits)
//   req_addr     12-bit CSR address
//   req_op       00 READ, 01 WRITE, 10 SET, 11 CLEAR
//   req_wdata    operand / mask
//   resp_valid   response strobe, one cycle after an accepted request
//   resp_rdata   old CSR value
//   resp_illegal access is illegal
interface rv_csr_mt_if #(
    parameter int HART_W = 2
) ();
    logic              req_valid;
    logic [HART_W-1:0] req_hart;
    logic [11:0]       req_addr;
    logic [1:0]        req_op;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_illegal;

    modport master (
        output req_valid, req_hart, req_addr, req_op, req_wdata,
        input  resp_valid, resp_rdata, resp_illegal
    );

    modport slave (
        input  req_valid, req_hart, req_addr, req_op, req_wdata,
        output resp_valid, resp_rdata, resp_illegal
    );
endinterface

// File: rtl/rv_csr_mt.sv
// rv_csr_mt: machine-mode CSR file for a multithreaded RISC-V core.
// Private CSR bank per hart (mstatus, mie, mtvec, mscratch, mepc, mcause,
// mtval), a shared mcycle counter and per-hart minstret counters.
// Performs CSRRW/CSRRS/CSRRC atomically; responds one cycle after accept.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            request accept enable (counters ignore it)
//   bus           rv_csr_mt_if.slave request/response bus
//   retire_valid  one instruction retired this cycle
//   retire_hart   hart of the retired instruction
// Optional feature macro RV_CSR_MT_COUNTINHIBIT_EN: adds a shared
// mcountinhibit at 0x320 (bit 0 freezes mcycle, bit 2 freezes minstret).
module rv_csr_mt #(
    parameter int          NUM_HARTS   = 4,
    parameter int          HART_W      = 2,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          CNT_WIDTH   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    rv_csr_mt_if.slave        bus,
    input  logic              retire_valid,
    input  logic [HART_W-1:0] retire_hart
);
    localparam int IDX_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int HI_W  = CNT_WIDTH - 32;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_MSTATUS,
        S_MIE,
        S_MTVEC,
        S_MSCRATCH,
        S_MEPC,
        S_MCAUSE,
        S_MTVAL
    } slot_e;

    logic [31:0]          bank     [NUM_HARTS][7];
    logic [CNT_WIDTH-1:0] mcycle;
    logic [CNT_WIDTH-1:0] minstret [NUM_HARTS];

    op_e              op;
    logic             accept;
    logic             hart_ok;
    logic [IDX_W-1:0] hidx;
    logic             addr_ok;
    logic             in_bank;
    slot_e            slot;
    logic [31:0]      wmask;
    logic [31:0]      old;
    logic [31:0]      wnew;
    logic             illegal;
    logic             do_write;
    logic             cy_run;
    logic             ir_run;

    assign op      = op_e'(bus.req_op);
    assign accept  = bus.req_valid & en;
    assign hart_ok = 32'(bus.req_hart) < 32'(NUM_HARTS);
    // Out-of-range harts are illegal anyway; clamp so array reads stay in bounds.
    assign hidx    = hart_ok ? IDX_W'(bus.req_hart) : '0;

`ifdef RV_CSR_MT_COUNTINHIBIT_EN
    logic [31:0] mcountinhibit;
    assign cy_run = ~mcountinhibit[0];
    assign ir_run = ~mcountinhibit[2];
`else
    assign cy_run = 1'b1;
    assign ir_run = 1'b1;
`endif

    // Address decode and old-value read.
    always_comb begin
        addr_ok = 1'b1;
        in_bank = 1'b0;
        slot    = S_MSTATUS;
        wmask   = '1;
        old     = '0;
        case (bus.req_addr)
            12'h300: begin in_bank = 1'b1; slot = S_MSTATUS;  wmask = 32'h0000_0088; end
            12'h304: begin in_bank = 1'b1; slot = S_MIE;      wmask = 32'h0000_0888; end
            12'h305: begin in_bank = 1'b1; slot = S_MTVEC;    wmask = 32'hFFFF_FFFC; end
            12'h340: begin in_bank = 1'b1; slot = S_MSCRATCH; end
            12'h341: begin in_bank = 1'b1; slot = S_MEPC;     wmask = 32'hFFFF_FFFE; end
            12'h342: begin in_bank = 1'b1; slot = S_MCAUSE;   end
            12'h343: begin in_bank = 1'b1; slot = S_MTVAL;    end
            12'hB00, 12'hC00: old = mcycle[31:0];
            12'hB80, 12'hC80: old = 32'(mcycle[CNT_WIDTH-1:32]);
            12'hB02, 12'hC02: old = minstret[hidx][31:0];
            12'hB82, 12'hC82: old = 32'(minstret[hidx][CNT_WIDTH-1:32]);
            12'hF14:          old = 32'(bus.req_hart);
`ifdef RV_CSR_MT_COUNTINHIBIT_EN
            12'h320: begin old = mcountinhibit; wmask = 32'h0000_0005; end
`endif
            default: addr_ok = 1'b0;
        endcase
        if (in_bank) begin
            old = bank[hidx][slot];
        end
    end

    always_comb begin
        illegal = ~addr_ok | ~hart_ok |
                  ((op != OP_READ) && (bus.req_addr[11:10] == 2'b11));
        case (op)
            OP_WRITE: wnew = bus.req_wdata;
            OP_SET:   wnew = old | bus.req_wdata;
            OP_CLEAR: wnew = old & ~bus.req_wdata;
            default:  wnew = old;
        endcase
        do_write = accept & ~illegal & (op != OP_READ);
    end

    // Per-hart CSR bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                for (int unsigned s = 0; s < 7; s++) begin
                    bank[h][s] <= '0;
                end
                bank[h][S_MTVEC] <= MTVEC_RESET & 32'hFFFF_FFFC;
            end
        end else if (do_write && in_bank) begin
            bank[hidx][slot] <= wnew & wmask;
        end
    end

`ifdef RV_CSR_MT_COUNTINHIBIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mcountinhibit <= '0;
        end else if (do_write && bus.req_addr == 12'h320) begin
            mcountinhibit <= wnew & wmask;
        end
    end
`endif

    // Counters: a CSR write replaces one half and suppresses that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle <= '0;
        end else if (do_write && bus.req_addr == 12'hB00) begin
            mcycle <= {mcycle[CNT_WIDTH-1:32], wnew};
        end else if (do_write && bus.req_addr == 12'hB80) begin
            mcycle <= {wnew[HI_W-1:0], mcycle[31:0]};
        end else if (cy_run) begin
            mcycle <= mcycle + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            if (rst) begin
                minstret[h] <= '0;
            end else if (do_write && 32'(hidx) == h && bus.req_addr == 12'hB02) begin
                minstret[h] <= {minstret[h][CNT_WIDTH-1:32], wnew};
            end else if (do_write && 32'(hidx) == h && bus.req_addr == 12'hB82) begin
                minstret[h] <= {wnew[HI_W-1:0], minstret[h][31:0]};
            end else if (ir_run && retire_valid && 32'(retire_hart) == h) begin
                minstret[h] <= minstret[h] + CNT_ONE;
            end
        end
    end

    // Response: rdata/illegal hold between accepted requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.resp_valid   <= 1'b0;
            bus.resp_rdata   <= '0;
            bus.resp_illegal <= 1'b0;
        end else begin
            bus.resp_valid <= accept;
            if (accept) begin
                bus.resp_rdata   <= illegal ? '0 : old;
                bus.resp_illegal <= illegal;
            end
        end
    end
endmodule

// File: tb/tb_rv_csr_mt.sv
module tb_rv_csr_mt;
    localparam int NH = 4;
    localparam int HW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          retire_valid = 1'b0;
    logic [HW-1:0] retire_hart = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_csr_mt_if #(.HART_W(HW)) bus ();

    rv_csr_mt #(
        .NUM_HARTS(NH),
        .HART_W(HW),
        .MTVEC_RESET(32'h0000_0100),
        .CNT_WIDTH(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .bus(bus),
        .retire_valid(retire_valid),
        .retire_hart(retire_hart)
    );

    // Reference model: architectural state as plain arrays and 64-bit integers.
    bit [31:0] m_csr [NH][7];
    bit [63:0] m_cyc;
    bit [63:0] m_ir [NH];
    bit [31:0] m_inh;
    bit        m_rv;
    bit [31:0] m_rd;
    bit        m_ill;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int csr_slot(input bit [11:0] a);
        case (a)
            12'h300: return 0;
            12'h304: return 1;
            12'h305: return 2;
            12'h340: return 3;
            12'h341: return 4;
            12'h342: return 5;
            12'h343: return 6;
            default: return -1;
        endcase
    endfunction

    function automatic bit [31:0] warl(input bit [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0888;
            12'h305: return 32'hFFFF_FFFC;
            12'h341: return 32'hFFFF_FFFE;
            12'h320: return 32'h0000_0005;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic bit is_impl(input bit [11:0] a);
        if (csr_slot(a) >= 0) return 1'b1;
        if (a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                      12'hC02, 12'hC82, 12'hF14}) return 1'b1;
`ifdef RV_CSR_MT_COUNTINHIBIT_EN
        if (a == 12'h320) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_cyc = '0;
        m_inh = '0;
        for (int h = 0; h < NH; h++) begin
            m_ir[h] = '0;
            for (int s = 0; s < 7; s++) m_csr[h][s] = '0;
            m_csr[h][2] = 32'h0000_0100 & warl(12'h305);
        end
        m_rv = 1'b0;
        m_rd = '0;
        m_ill = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the
    // DUT and compare its response outputs.
    task automatic step();
        bit        acc;
        bit        ill;
        bit        wr;
        bit [31:0] old;
        bit [31:0] nv;
        bit [63:0] c0;
        bit [11:0] a;
        int        h;
        int        s;
        if (rst) begin
            m_reset();
        end else begin
            a   = bus.req_addr;
            h   = int'(bus.req_hart);
            s   = csr_slot(a);
            acc = bus.req_valid && en;
            ill = !is_impl(a) || h >= NH || (bus.req_op != 2'b00 && a[11:10] == 2'b11);
            old = '0;
            if (!ill) begin
                if (s >= 0) old = m_csr[h][s];
                else case (a)
                    12'hB00, 12'hC00: old = m_cyc[31:0];
                    12'hB80, 12'hC80: old = m_cyc[63:32];
                    12'hB02, 12'hC02: old = m_ir[h][31:0];
                    12'hB82, 12'hC82: old = m_ir[h][63:32];
                    12'hF14:          old = 32'(h);
                    default:          old = m_inh;
                endcase
            end
            case (bus.req_op)
                2'b01:   nv = bus.req_wdata;
                2'b10:   nv = old | bus.req_wdata;
                2'b11:   nv = old & ~bus.req_wdata;
                default: nv = old;
            endcase
            wr = acc && !ill && bus.req_op != 2'b00;

            c0 = m_cyc;
            if (wr && a == 12'hB00)      m_cyc = {c0[63:32], nv};
            else if (wr && a == 12'hB80) m_cyc = {nv, c0[31:0]};
            else if (!m_inh[0])          m_cyc = c0 + 64'd1;

            for (int k = 0; k < NH; k++) begin
                c0 = m_ir[k];
                if (wr && h == k && a == 12'hB02)      m_ir[k] = {c0[63:32], nv};
                else if (wr && h == k && a == 12'hB82) m_ir[k] = {nv, c0[31:0]};
                else if (!m_inh[2] && retire_valid && int'(retire_hart) == k) m_ir[k] = c0 + 64'd1;
            end

            if (wr && s >= 0)      m_csr[h][s] = nv & warl(a);
            if (wr && a == 12'h320) m_inh = nv & warl(a);

            m_rv = acc;
            if (acc) begin
                m_rd  = ill ? 32'h0 : old;
                m_ill = ill;
            end
        end
        @(posedge clk);
        #1;
        check("resp_valid", 64'(bus.resp_valid), 64'(m_rv));
        check("resp_rdata", 64'(bus.resp_rdata), 64'(m_rd));
        check("resp_illegal", 64'(bus.resp_illegal), 64'(m_ill));
    endtask

    task automatic req(input bit v, input int hart, input bit [11:0] a,
                       input bit [1:0] op, input bit [31:0] wd);
        bus.req_valid = v;
        bus.req_hart  = HW'(hart);
        bus.req_addr  = a;
        bus.req_op    = op;
        bus.req_wdata = wd;
        step();
    endtask

    bit [11:0] addr_pool [20] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02,
                                  12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                                  12'hF14, 12'h320, 12'h7C0, 12'h301, 12'hFFF};

    initial begin
        bus.req_valid = 1'b0;
        bus.req_hart  = '0;
        bus.req_addr  = '0;
        bus.req_op    = '0;
        bus.req_wdata = '0;
        rst = 1'b1;
        en  = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_valid", 64'(bus.resp_valid), 64'd0);
        check("reset_rdata", 64'(bus.resp_rdata), 64'd0);

        // Reset values and mhartid.
        req(1, 1, 12'h305, 2'b00, 32'h0);
        check("mtvec_reset", 64'(bus.resp_rdata), 64'h100);
        req(1, 3, 12'hF14, 2'b00, 32'h0);
        check("mhartid3", 64'(bus.resp_rdata), 64'd3);

        // Back-to-back read-modify-write on mscratch.
        req(1, 0, 12'h340, 2'b01, 32'hDEADBEEF);
        check("mscr_w", 64'(bus.resp_rdata), 64'h0);
        req(1, 0, 12'h340, 2'b10, 32'h1);
        check("mscr_s", 64'(bus.resp_rdata), 64'hDEADBEEF);
        req(1, 0, 12'h340, 2'b11, 32'hFF);
        check("mscr_c", 64'(bus.resp_rdata), 64'hDEADBEEF);
        req(1, 0, 12'h340, 2'b00, 32'h0);
        check("mscr_final", 64'(bus.resp_rdata), 64'hDEADBE00);
        req(1, 1, 12'h340, 2'b00, 32'h0);
        check("mscr_hart1", 64'(bus.resp_rdata), 64'h0);

        // WARL masking.
        req(1, 0, 12'h300, 2'b01, 32'hFFFF_FFFF);
        req(1, 0, 12'h300, 2'b00, 32'h0);
        check("mstatus_warl", 64'(bus.resp_rdata), 64'h88);
        req(1, 0, 12'h305, 2'b01, 32'h1003);
        req(1, 0, 12'h305, 2'b00, 32'h0);
        check("mtvec_warl", 64'(bus.resp_rdata), 64'h1000);

        // Illegal accesses.
        req(1, 0, 12'hC00, 2'b01, 32'h1234);
        check("ill_ro", 64'(bus.resp_illegal), 64'd1);
        req(1, 0, 12'h7C0, 2'b00, 32'h0);
        check("ill_addr", 64'(bus.resp_illegal), 64'd1);
        req(1, 5, 12'h340, 2'b00, 32'h0);
        check("ill_hart", 64'(bus.resp_illegal), 64'd1);
        check("ill_hart_rd", 64'(bus.resp_rdata), 64'd0);

        // mcycle write, then carry into mcycleh on the next increment.
        req(1, 2, 12'hB80, 2'b01, 32'h0);
        req(1, 2, 12'hB00, 2'b01, 32'hFFFF_FFFF);
        req(1, 0, 12'hB00, 2'b00, 32'h0);
        check("mcycle_lo", 64'(bus.resp_rdata), 64'hFFFF_FFFF);
        req(1, 0, 12'hB80, 2'b00, 32'h0);
        check("mcycle_hi", 64'(bus.resp_rdata), 64'h1);

        // minstret write collides with a retire on the same hart.
        retire_valid = 1'b1;
        retire_hart  = 3'd2;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) req(1, 2, 12'hB02, 2'b01, 32'd5);
            else        req(0, 0, 12'h000, 2'b00, 32'h0);
        end
        retire_valid = 1'b0;
        req(1, 2, 12'hC02, 2'b00, 32'h0);
        check("instret_h2", 64'(bus.resp_rdata), 64'd10);
        req(1, 0, 12'hC02, 2'b00, 32'h0);
        check("instret_h0", 64'(bus.resp_rdata), 64'd0);

`ifdef RV_CSR_MT_COUNTINHIBIT_EN
        req(1, 1, 12'h320, 2'b01, 32'h4);
        retire_valid = 1'b1;
        for (int i = 0; i < 3; i++) req(0, 0, 12'h000, 2'b00, 32'h0);
        retire_valid = 1'b0;
        req(1, 2, 12'hC02, 2'b00, 32'h0);
        check("instret_inh", 64'(bus.resp_rdata), 64'd10);
        req(1, 0, 12'h320, 2'b01, 32'h0);
`endif

        // en low blocks acceptance; rdata/illegal hold.
        en = 1'b0;
        req(1, 0, 12'h340, 2'b01, 32'h5555_5555);
        check("en_low_valid", 64'(bus.resp_valid), 64'd0);
        en = 1'b1;

        // Reset mid-operation drops the in-flight response.
        bus.req_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_valid", 64'(bus.resp_valid), 64'd0);
        req(1, 0, 12'h340, 2'b00, 32'h0);
        check("rst_mid_mscr", 64'(bus.resp_rdata), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en           = ($urandom_range(0, 4) != 0);
            retire_valid = $urandom_range(0, 1) == 1;
            retire_hart  = HW'($urandom_range(0, 5));
            req($urandom_range(0, 9) < 7,
                $urandom_range(0, 5),
                addr_pool[$urandom_range(0, 19)],
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
